// File: rtl/capture_pkg.sv
// Shared types and the round-robin search helper for capture_bank.
// The search works on a 16-wide pending vector so that one function serves every channel count.
package capture_pkg;

  localparam int TS_W   = 16;
  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] winner;
  } rr_result_t;

  // The search starts at the channel after 'last' and wraps modulo nch.
  // Bits of pend at or above nch are never looked at.
  function automatic rr_result_t rr_next(input logic [MAX_CH-1:0] pend,
                                         input logic [IDX_W-1:0]  last,
                                         input int                nch);
    rr_result_t res;
    int         idx;
    res = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      idx = (int'(last) + k) % nch;
      if (k <= nch && !res.hit && pend[idx[IDX_W-1:0]]) begin
        res.hit    = 1'b1;
        res.winner = idx[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/capture_rr_arb.sv
// Combinational round-robin search over the per-channel pending flags.
module capture_rr_arb
  import capture_pkg::*;
#(
  parameter  int NCH = 3,
  localparam int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] pend,
  input  logic [CHW-1:0] last,
  output logic [CHW-1:0] winner,
  output logic           hit
);

  rr_result_t res;
  logic       unused_winner;

  always_comb begin
    res = rr_next(MAX_CH'(pend), IDX_W'(last), NCH);
  end

  // The winner is always below NCH, so the upper index bits carry nothing.
  assign unused_winner = ^res.winner;
  assign winner        = res.winner[CHW-1:0];
  assign hit           = res.hit;

endmodule

// File: rtl/capture_bank.sv
// Multi-channel capture register bank drained by one round-robin valid/ready output stage.
// Defining CAPTURE_TIMESTAMP_EN adds a free-running timestamp captured per channel and the out_ts port.
module capture_bank
  import capture_pkg::*;
#(
  parameter  int               NCH     = 3,
  parameter  int               DW      = 8,
  parameter  logic [NCH*DW-1:0] RST_VAL = {NCH*DW{1'b0}},
  localparam int               CHW     = $clog2(NCH)
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [NCH*DW-1:0] ival,
  input  logic [NCH-1:0]    load,
  input  logic [NCH-1:0]    clr_ovr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CHW-1:0]    out_ch,
  output logic [NCH-1:0]    pend,
  output logic [NCH-1:0]    overrun
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   out_ts
`endif
);

  logic [DW-1:0]  cap [NCH];
  out_state_t     state, state_nxt;
  logic [CHW-1:0] last, winner;
  logic           hit, take;
  logic [NCH-1:0] grant;

  capture_rr_arb #(.NCH(NCH)) u_arb (
    .pend   (pend),
    .last   (last),
    .winner (winner),
    .hit    (hit)
  );

  // A selection may happen whenever the stage is empty or its value leaves this cycle.
  assign take = (state == EMPTY) || out_ready;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      grant[i] = take && hit && (winner == CHW'(i));
    end
  end

  // A load on the channel being selected keeps pend set and is not an overrun:
  // the output takes the old value and the new one waits its turn.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cap[i] <= RST_VAL[i*DW +: DW];
      end
      pend    <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          cap[i]  <= ival[i*DW +: DW];
          pend[i] <= 1'b1;
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
        overrun[i] <= (overrun[i] & ~clr_ovr[i]) | (load[i] & pend[i] & ~grant[i]);
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (take) state_nxt = hit ? FULL : EMPTY;
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_ch   <= '0;
      last     <= CHW'(NCH - 1);
    end else if (take && hit) begin
      out_data <= cap[winner];
      out_ch   <= winner;
      last     <= winner;
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_cap [NCH];

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      ts     <= '0;
      out_ts <= '0;
      for (int i = 0; i < NCH; i++) begin
        ts_cap[i] <= '0;
      end
    end else begin
      ts <= ts + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) ts_cap[i] <= ts;
      end
      if (take && hit) out_ts <= ts_cap[winner];
    end
  end
`endif

endmodule

// File: tb/tb_capture_bank.sv
// Directed self-checking bench for capture_bank (NCH=3, DW=8, RST_VAL=0x0C0B0A).
// The timestamp steps are compiled in only when CAPTURE_TIMESTAMP_EN is defined.
module tb_capture_bank;
  import capture_pkg::*;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int CHW = $clog2(NCH);

  logic              sysclk = 1'b0;
  logic              reset;
  logic [NCH*DW-1:0] ival;
  logic [NCH-1:0]    load;
  logic [NCH-1:0]    clr_ovr;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_ch;
  logic [NCH-1:0]    pend;
  logic [NCH-1:0]    overrun;
`ifdef CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]   out_ts;
`endif

  int compared   = 0;
  int mismatched = 0;

  capture_bank #(.NCH(NCH), .DW(DW), .RST_VAL(24'h0C0B0A)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .ival      (ival),
    .load      (load),
    .clr_ovr   (clr_ovr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .pend      (pend),
    .overrun   (overrun)
`ifdef CAPTURE_TIMESTAMP_EN
    ,
    .out_ts    (out_ts)
`endif
  );

  always #5 sysclk = ~sysclk;

  task automatic applyStimulus(input logic [NCH-1:0] ld, input logic [NCH*DW-1:0] iv,
                               input logic rdy, input logic [NCH-1:0] clr);
    load      = ld;
    ival      = iv;
    out_ready = rdy;
    clr_ovr   = clr;
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStage(input string tag, input logic v, input logic [DW-1:0] d,
                            input logic [CHW-1:0] ch, input logic [NCH-1:0] p);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      checkOutput({tag, ".data"}, 32'(out_data), 32'(d));
      checkOutput({tag, ".ch"}, 32'(out_ch), 32'(ch));
    end
    checkOutput({tag, ".pend"}, 32'(pend), 32'(p));
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 1'b0, '0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] capture_bank directed test start");
    reset = 1'b1;
    applyStimulus('0, '0, 1'b0, '0);
    #2;
    // Reset state, including the per-channel reset capture values.
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.data", 32'(out_data), 32'd0);
    checkOutput("rst.ch", 32'(out_ch), 32'd0);
    checkOutput("rst.pend", 32'(pend), 32'd0);
    checkOutput("rst.overrun", 32'(overrun), 32'd0);
    checkOutput("rst.cap0", 32'(dut.cap[0]), 32'h0A);
    checkOutput("rst.cap1", 32'(dut.cap[1]), 32'h0B);
    checkOutput("rst.cap2", 32'(dut.cap[2]), 32'h0C);
    #1;
    reset = 1'b0;

    // Single capture on ch0.
    applyStimulus(3'b001, 24'h332211, 1'b0, '0);
    tick();
    checkStage("single.load", 1'b0, 8'h00, 2'd0, 3'b001);
    applyStimulus('0, 24'h332211, 1'b0, '0);
    tick();
    checkStage("single.out", 1'b1, 8'h11, 2'd0, 3'b000);

    // Fairness: all three pending drain in channel order after reset.
    doReset();
    applyStimulus(3'b111, 24'h332211, 1'b1, '0);
    tick();
    checkStage("fair.load", 1'b0, 8'h00, 2'd0, 3'b111);
    applyStimulus('0, '0, 1'b1, '0);
    tick();
    checkStage("fair.ch0", 1'b1, 8'h11, 2'd0, 3'b110);
    tick();
    checkStage("fair.ch1", 1'b1, 8'h22, 2'd1, 3'b100);
    tick();
    checkStage("fair.ch2", 1'b1, 8'h33, 2'd2, 3'b000);
    tick();
    checkStage("fair.empty", 1'b0, 8'h00, 2'd0, 3'b000);

    // Fill the stage with ch0 then overrun ch1 under backpressure.
    applyStimulus(3'b001, 24'h000099, 1'b0, '0);
    tick();
    applyStimulus('0, '0, 1'b0, '0);
    tick();
    checkStage("ovr.fill", 1'b1, 8'h99, 2'd0, 3'b000);
    applyStimulus(3'b010, 24'h004400, 1'b0, '0);
    tick();
    checkOutput("ovr.first", 32'(overrun), 32'd0);
    applyStimulus(3'b010, 24'h005500, 1'b0, '0);
    tick();
    checkOutput("ovr.set", 32'(overrun), 32'b010);
    checkStage("ovr.hold", 1'b1, 8'h99, 2'd0, 3'b010);
    applyStimulus(3'b010, 24'h005500, 1'b0, 3'b010);
    tick();
    checkOutput("ovr.setwins", 32'(overrun), 32'b010);
    applyStimulus('0, '0, 1'b0, 3'b010);
    tick();
    checkOutput("ovr.clear", 32'(overrun), 32'd0);

    // Backpressure: the presented value stays put for five more cycles.
    applyStimulus('0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkStage("bp.hold", 1'b1, 8'h99, 2'd0, 3'b010);
    end
    applyStimulus('0, '0, 1'b1, '0);
    tick();
    checkStage("bp.next", 1'b1, 8'h55, 2'd1, 3'b000);
    tick();
    checkStage("bp.empty", 1'b0, 8'h00, 2'd0, 3'b000);

    // Load on ch2 in the same cycle it is selected.
    applyStimulus(3'b100, 24'h660000, 1'b0, '0);
    tick();
    checkStage("same.load", 1'b0, 8'h00, 2'd0, 3'b100);
    applyStimulus(3'b100, 24'h770000, 1'b0, '0);
    tick();
    checkStage("same.sel", 1'b1, 8'h66, 2'd2, 3'b100);
    checkOutput("same.overrun", 32'(overrun), 32'd0);
    applyStimulus('0, '0, 1'b1, '0);
    tick();
    checkStage("same.next", 1'b1, 8'h77, 2'd2, 3'b000);
    tick();
    checkStage("same.empty", 1'b0, 8'h00, 2'd0, 3'b000);

`ifdef CAPTURE_TIMESTAMP_EN
    // Captures straddling the counter wrap.
    doReset();
    repeat (65534) tick();
    applyStimulus(3'b001, 24'h0000A1, 1'b0, '0);
    tick();
    applyStimulus('0, '0, 1'b0, '0);
    tick();
    applyStimulus(3'b010, 24'h00B200, 1'b0, '0);
    tick();
    checkStage("ts.ch0", 1'b1, 8'hA1, 2'd0, 3'b010);
    checkOutput("ts.ch0.ts", 32'(out_ts), 32'hFFFE);
    applyStimulus('0, '0, 1'b1, '0);
    tick();
    checkStage("ts.ch1", 1'b1, 8'hB2, 2'd1, 3'b000);
    checkOutput("ts.ch1.ts", 32'(out_ts), 32'h0000);
`endif

    // Asynchronous reset in the middle of a drain.
    doReset();
    applyStimulus(3'b111, 24'h332211, 1'b0, '0);
    tick();
    applyStimulus('0, '0, 1'b0, '0);
    tick();
    checkStage("mid.before", 1'b1, 8'h11, 2'd0, 3'b110);
    reset = 1'b1;
    #1;
    checkStage("mid.async", 1'b0, 8'h00, 2'd0, 3'b000);
    checkOutput("mid.data", 32'(out_data), 32'd0);
`ifdef CAPTURE_TIMESTAMP_EN
    checkOutput("mid.ts", 32'(dut.ts), 32'd0);
`endif
    #1;
    reset = 1'b0;
    tick();
    checkStage("mid.after", 1'b0, 8'h00, 2'd0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/capture_bank.md
# capture_bank

Parametrised multi-channel capture register bank. Each channel latches its own slice of a shared input word on a per-channel load strobe. A single round-robin output stage drains the captured values over a valid/ready stream. It sits between free-running status/sample sources and a single consumer, such as a register-read or trace path, and generalises fixed per-register slice capture to NCH channels with pending, overrun and arbitration behaviour.

## Interface
Parameters:
- NCH, 3, number of channels (2..16)
- DW, 8, data width per channel
- RST_VAL, {NCH*DW{1'b0}}, per-channel reset value; channel i uses bits [i*DW +: DW]
- CHW, $clog2(NCH), channel index width (derived, not overridden)

Ports:
- sysclk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ival  in  NCH*DW  input word; channel i slice = ival[i*DW +: DW]
- load  in  NCH  per-channel capture strobe, one cycle per capture
- clr_ovr  in  NCH  per-channel overrun clear
- out_valid  out  1  output stage holds a captured value
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  DW  captured value being presented
- out_ch  out  CHW  channel index of out_data
- pend  out  NCH  channel captured and not yet moved to output stage
- overrun  out  NCH  sticky: capture overwrote a pending value
- out_ts  out  16  capture timestamp of out_data (CAPTURE_TIMESTAMP_EN only)

## Operation
- Reset values:
  - cap[i] = RST_VAL slice i
  - pend = 0, overrun = 0
  - out_valid = 0, out_data = 0, out_ch = 0, out_ts = 0
  - round-robin pointer last = NCH-1
- Capture: load[i] at an edge sets cap[i] <= ival slice i and pend[i] <= 1.
- Overrun: load[i] while pend[i]=1 and channel i not selected that cycle:
  - data overwritten, newest wins;
  - overrun[i] <= 1.
- clr_ovr[i] clears overrun[i]. If a new overrun on i occurs in the same cycle, set wins.
- Output stage, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1. out_data, out_ch and out_ts are held stable until accepted.
- Selection happens when the stage is EMPTY, or FULL and accepted this cycle:
  - first channel with pend=1, searching last+1, last+2, … modulo NCH;
  - on a hit, load the output registers, clear pend of the winner, set last = winner, and enter or stay FULL;
  - if nothing is pending, go to EMPTY (FULL with accept -> EMPTY).
- Selection and a load on the same channel in the same cycle:
  - the output takes the old cap value;
  - pend stays 1 and cap takes the new value;
  - no overrun is raised.
- load bits for multiple channels may be set in the same cycle; each channel is independent.
- Reset mid-operation discards pending and output data immediately (asynchronous).

## Timing
- load sampled at edge k: pend[i]=1 after k.
- Earliest out_valid=1 with data is after edge k+1, if the stage is free.
- Back-to-back acceptance sustains one transfer per cycle when ≥1 channel is pending.
- The output is fully registered; out_ready has no combinational path to out_valid or out_data.
- pend and overrun are registered and update one edge after their cause.

## Configuration
- Macro: CAPTURE_TIMESTAMP_EN.
- Defined:
  - a 16-bit free-running counter ts increments every cycle from 0 at reset and wraps 0xFFFF -> 0x0000;
  - each capture latches ts into ts_cap[i];
  - out_ts is loaded with ts_cap[winner] alongside out_data;
  - an overwriting capture also overwrites ts_cap.
- Undefined: no counter, no ts_cap storage, no out_ts port. All other behaviour is identical.

## Structure
- Shared package capture_pkg holds:
  - TS_W = 16;
  - the output state enum (EMPTY, FULL);
  - function rr_next(pend, last), returning winner index and hit flag.
- One sub-module: capture_rr_arb (combinational round-robin search, NCH parameter), instantiated once.
- Capture registers, flags and the output stage stay in capture_bank.

## Test plan
- Reset and single capture:
  - during reset, cap = RST_VAL; NCH=3, RST_VAL=0x0C0B0A, out_valid=0;
  - load=001 with ival=0x332211: pend=001 next cycle, then out_valid=1, out_data=0x11, out_ch=0, pend=000.
- Fairness: load=111 once, out_ready=1 -> outputs ch0, ch1, ch2 on consecutive cycles (0x11, 0x22, 0x33), then out_valid=0.
- Overrun: out_ready=0, load ch1 with 0x44 then 0x55 -> overrun=010, and ch1 later drains 0x55 only. clr_ovr=010 with a simultaneous new overrun -> overrun stays 010.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data and out_ch constant; on release, the next pending channel follows in the following cycle.
- Same-cycle select and load: load ch2 0x66, then load ch2 0x77 on the edge it is selected -> output 0x66, pend[2]=1, overrun[2]=0, next output 0x77.
- With CAPTURE_TIMESTAMP_EN: load ch0 at ts=0xFFFE and ch1 at ts=0x0000 after wrap -> out_ts 0xFFFE then 0x0000. Asserting reset mid-stream clears out_valid, pend and ts asynchronously.
